reg_dump_sequencer: RTL and testbench

//  Hardware single-step and register-dump engine for the single-cycle MIPS core.
//  It drives the core's register-select and run-enable inputs to snapshot a

---
 rtl/reg_dump_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_reg_dump_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_sequencer.sv
// Single-step and register-dump engine for the single-cycle MIPS core: snapshots the
// registers selected by REG_MASK, steps the core with a run pulse, and repeats.
module reg_dump_sequencer #(
  parameter int                      DATA_W   = 32,
  parameter int                      ADDR_W   = 5,
  parameter logic [(2**ADDR_W)-1:0]  REG_MASK = 32'h03FF_FF00,
  parameter int                      SETTLE   = 2,
  parameter int                      RUN_CYC  = 16,
  parameter int                      STEP_W   = 16
) (
  input  logic              clkFast,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [STEP_W-1:0] num_steps,
  output logic [ADDR_W-1:0] sel,
  input  logic [DATA_W-1:0] rd_data,
  output logic              run,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic [STEP_W-1:0] out_frame,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int NREG       = 2**ADDR_W;
  localparam int TMR_MAX    = (SETTLE > RUN_CYC) ? SETTLE : RUN_CYC;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);
  localparam bit MASK_EMPTY = (REG_MASK == '0);

  function automatic logic [ADDR_W-1:0] first_set();
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--)
      if (REG_MASK[i]) idx = ADDR_W'(i);
    return idx;
  endfunction

  localparam logic [ADDR_W-1:0] FIRST_IDX = first_set();

  typedef enum logic [2:0] {
    ST_IDLE, ST_SEL, ST_SETTLE, ST_CAP, ST_RUN, ST_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  timer, timer_nxt;
  logic [STEP_W-1:0] step_cnt, step_cnt_nxt;
  logic [STEP_W-1:0] steps_r, steps_nxt;
  logic              stop_lat, stop_lat_nxt;
  logic [ADDR_W-1:0] sel_nxt, out_idx_nxt;
  logic [DATA_W-1:0] out_data_nxt;
  logic [STEP_W-1:0] out_frame_nxt;
  logic              run_nxt, out_valid_nxt, out_last_nxt, busy_nxt, done_nxt;
  logic              nxt_found;
  logic [ADDR_W-1:0] nxt_idx;
  logic              end_now;

  // Next register in the dump list above the one currently selected.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (REG_MASK[i] && (i > int'(sel))) begin
        nxt_found = 1'b1;
        nxt_idx   = ADDR_W'(i);
      end
    end
  end

  assign end_now = stop_lat || stop || ((steps_r != '0) && (step_cnt == steps_r));

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    step_cnt_nxt  = step_cnt;
    steps_nxt     = steps_r;
    stop_lat_nxt  = stop_lat | (stop && (state != ST_IDLE));
    sel_nxt       = sel;
    run_nxt       = run;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_idx_nxt   = out_idx;
    out_frame_nxt = out_frame;
    out_last_nxt  = out_last;

    case (state)
      ST_IDLE: begin
        if (start) begin
          step_cnt_nxt = '0;
          steps_nxt    = num_steps;
          stop_lat_nxt = 1'b0;
          sel_nxt      = FIRST_IDX;
          timer_nxt    = '0;
          state_nxt    = ST_SEL;
        end
      end
      ST_SEL, ST_SETTLE: begin
        // An empty mask makes every frame end immediately after its SEL cycle.
        if (MASK_EMPTY) begin
          timer_nxt = '0;
          if (end_now) begin
            state_nxt = ST_DONE;
          end else begin
            run_nxt   = 1'b1;
            state_nxt = ST_RUN;
          end
        end else if (timer == TMR_W'(SETTLE - 1)) begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = rd_data;
          out_idx_nxt   = sel;
          out_frame_nxt = step_cnt;
          out_last_nxt  = !nxt_found;
          state_nxt     = ST_CAP;
        end else begin
          timer_nxt = timer + TMR_W'(1);
          state_nxt = ST_SETTLE;
        end
      end
      ST_CAP: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          timer_nxt     = '0;
          if (nxt_found) begin
            sel_nxt   = nxt_idx;
            state_nxt = ST_SEL;
          end else if (end_now) begin
            state_nxt = ST_DONE;
          end else begin
            run_nxt   = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (timer == TMR_W'(RUN_CYC - 1)) begin
          run_nxt      = 1'b0;
          step_cnt_nxt = step_cnt + STEP_W'(1);
          sel_nxt      = FIRST_IDX;
          timer_nxt    = '0;
          state_nxt    = ST_SEL;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        run_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clkFast or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      step_cnt  <= '0;
      steps_r   <= '0;
      stop_lat  <= 1'b0;
      sel       <= '0;
      run       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_frame <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      step_cnt  <= step_cnt_nxt;
      steps_r   <= steps_nxt;
      stop_lat  <= stop_lat_nxt;
      sel       <= sel_nxt;
      run       <= run_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_idx   <= out_idx_nxt;
      out_frame <= out_frame_nxt;
      out_last  <= out_last_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Scoreboard bench for reg_dump_sequencer: a frame-list model predicts every beat and
// monitors check beats, run pulse widths, hold-under-stall and done/busy behaviour.
module tb_reg_dump_sequencer;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int STEP_W  = 16;
  localparam int RUN_CYC = 16;
  localparam logic [31:0] MASK = 32'h03FF_FF00;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] idx;
    logic [STEP_W-1:0] frame;
    logic              last;
  } beat_t;

  logic              clkFast = 1'b0;
  logic              reset   = 1'b1;
  logic              start   = 1'b0;
  logic              stop    = 1'b0;
  logic [STEP_W-1:0] num_steps = '0;
  logic [ADDR_W-1:0] sel;
  logic [DATA_W-1:0] rd_data;
  logic              run, out_valid, out_last, busy, done;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic [STEP_W-1:0] out_frame;
  logic [DATA_W-1:0] salt = '0;

  logic              start_e = 1'b0;
  logic              stop_e  = 1'b0;
  logic [STEP_W-1:0] num_steps_e = '0;
  logic [ADDR_W-1:0] sel_e;
  logic [DATA_W-1:0] rd_data_e;
  logic              run_e, out_valid_e, out_last_e, busy_e, done_e;
  logic              out_ready_e = 1'b1;
  logic [DATA_W-1:0] out_data_e;
  logic [ADDR_W-1:0] out_idx_e;
  logic [STEP_W-1:0] out_frame_e;

  int    n_compared   = 0;
  int    n_mismatched = 0;
  beat_t exp_q[$];
  int    run_pulses   = 0;
  int    done_cnt     = 0;
  int    run_pulses_e = 0;
  int    done_cnt_e   = 0;
  bit    seen_valid_e = 0;

  assign rd_data   = (32'(sel) * 32'h0101_0101) ^ salt;
  assign rd_data_e = 32'(sel_e);

  reg_dump_sequencer dut (
    .clkFast(clkFast), .reset(reset), .start(start), .stop(stop),
    .num_steps(num_steps), .sel(sel), .rd_data(rd_data), .run(run),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_frame(out_frame), .out_last(out_last),
    .busy(busy), .done(done)
  );

  reg_dump_sequencer #(.REG_MASK(32'h0)) dut_empty (
    .clkFast(clkFast), .reset(reset), .start(start_e), .stop(stop_e),
    .num_steps(num_steps_e), .sel(sel_e), .rd_data(rd_data_e), .run(run_e),
    .out_valid(out_valid_e), .out_ready(out_ready_e), .out_data(out_data_e),
    .out_idx(out_idx_e), .out_frame(out_frame_e), .out_last(out_last_e),
    .busy(busy_e), .done(done_e)
  );

  initial forever #5 clkFast = ~clkFast;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Reference model: a frame is every masked register in ascending order.
  task automatic push_frame(input int f);
    int hi;
    beat_t b;
    hi = -1;
    for (int i = 0; i < 32; i++) if (MASK[i]) hi = i;
    for (int i = 0; i < 32; i++) begin
      if (MASK[i]) begin
        b.data  = (32'(i) * 32'h0101_0101) ^ salt;
        b.idx   = ADDR_W'(i);
        b.frame = STEP_W'(f);
        b.last  = (i == hi);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic applyStimulus(input int steps, input int frames);
    salt = $urandom;
    num_steps = STEP_W'(steps);
    for (int f = 0; f < frames; f++) push_frame(f);
    @(posedge clkFast); #1;
    start = 1'b1;
    @(posedge clkFast); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit rnd_ready, input int restart_at,
                                input int stop_frame, input int stop_idx, input int stall_idx);
    int cyc, stall_state, stall_cnt;
    bit got_done;
    cyc = 0; stall_state = 0; stall_cnt = 0; got_done = 0;
    while (!got_done && cyc < budget) begin
      @(posedge clkFast); #1;
      cyc++;
      num_steps = STEP_W'($urandom);
      start = (cyc == restart_at);
      stop  = (stop_frame >= 0) && out_valid && (int'(out_frame) == stop_frame) &&
              (int'(out_idx) == stop_idx);
      if (stall_idx >= 0 && stall_state == 0 && int'(sel) == stall_idx && !out_valid) begin
        out_ready   = 1'b0;
        stall_state = 1;
      end else if (stall_state == 1) begin
        if (out_valid) stall_cnt++;
        if (stall_cnt > 5) begin
          out_ready   = 1'b1;
          stall_state = 2;
        end
      end else begin
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (done) got_done = 1;
    end
    start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    checkOutput("done_seen", 64'(got_done), 1);
    @(posedge clkFast); #1;
    checkOutput("busy_after_done", 64'(busy), 0);
    checkOutput("beats_missing", 64'(exp_q.size()), 0);
  endtask

  task automatic check_reset_state();
    checkOutput("rst_sel", 64'(sel), 0);
    checkOutput("rst_run", 64'(run), 0);
    checkOutput("rst_out_valid", 64'(out_valid), 0);
    checkOutput("rst_out_data", 64'(out_data), 0);
    checkOutput("rst_out_idx", 64'(out_idx), 0);
    checkOutput("rst_out_frame", 64'(out_frame), 0);
    checkOutput("rst_out_last", 64'(out_last), 0);
    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_done", 64'(done), 0);
  endtask

  // Scoreboard: pop and compare on every accepted beat.
  initial forever begin
    beat_t e;
    @(negedge clkFast);
    if (reset && out_valid) checkOutput("run_during_frame", 64'(run), 0);
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 64'(out_idx), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("beat_data", 64'(out_data), 64'(e.data));
        checkOutput("beat_idx", 64'(out_idx), 64'(e.idx));
        checkOutput("beat_frame", 64'(out_frame), 64'(e.frame));
        checkOutput("beat_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  // Held outputs must not move while the consumer stalls.
  initial begin
    bit stall_prev;
    logic [DATA_W-1:0] h_data;
    logic [ADDR_W-1:0] h_idx, h_sel;
    logic [STEP_W-1:0] h_frame;
    logic h_last;
    stall_prev = 0;
    forever begin
      @(negedge clkFast);
      if (!reset) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          checkOutput("hold_valid", 64'(out_valid), 1);
          checkOutput("hold_data", 64'(out_data), 64'(h_data));
          checkOutput("hold_idx", 64'(out_idx), 64'(h_idx));
          checkOutput("hold_sel", 64'(sel), 64'(h_sel));
          checkOutput("hold_frame", 64'(out_frame), 64'(h_frame));
          checkOutput("hold_last", 64'(out_last), 64'(h_last));
        end
        stall_prev = out_valid && !out_ready;
        h_data = out_data; h_idx = out_idx; h_sel = sel; h_frame = out_frame; h_last = out_last;
      end
    end
  end

  // Run pulse widths and done pulses of the main instance.
  initial begin
    int len;
    bit prev_done;
    len = 0; prev_done = 0;
    forever begin
      @(negedge clkFast);
      if (!reset) begin
        len = 0; prev_done = 0;
      end else begin
        if (run) begin
          len++;
        end else if (len != 0) begin
          checkOutput("run_width", 64'(len), RUN_CYC);
          run_pulses++;
          len = 0;
        end
        if (done) begin
          done_cnt++;
          checkOutput("done_width", 64'(prev_done), 0);
          checkOutput("busy_at_done", 64'(busy), 1);
        end
        prev_done = done;
      end
    end
  end

  // Empty-mask instance: pulse widths, one-cycle gaps, no beats.
  initial begin
    int len, gap;
    len = 0; gap = 0;
    forever begin
      @(negedge clkFast);
      if (!reset) begin
        len = 0; gap = 0;
      end else begin
        if (out_valid_e) seen_valid_e = 1;
        if (run_e) begin
          if (len == 0 && run_pulses_e > 0) checkOutput("empty_gap", 64'(gap), 1);
          len++;
          gap = 0;
        end else begin
          if (len != 0) begin
            checkOutput("empty_run_width", 64'(len), RUN_CYC);
            run_pulses_e++;
            len = 0;
          end
          gap++;
        end
        if (done_e) done_cnt_e++;
      end
    end
  end

  initial begin
    int p0, d0, steps, run_seen, cyc;
    bit got;
    #1 reset = 1'b0;
    #3 check_reset_state();
    repeat (3) @(posedge clkFast);
    #1 reset = 1'b1;

    // T1: default mask, two steps, consumer always ready.
    p0 = run_pulses; d0 = done_cnt;
    applyStimulus(2, 3);
    run_until_done(4000, 0, -1, -1, -1, -1);
    checkOutput("t1_run_pulses", 64'(run_pulses - p0), 2);
    checkOutput("t1_done_count", 64'(done_cnt - d0), 1);

    // T2: stall on beat 3 (idx 10).
    p0 = run_pulses;
    applyStimulus(1, 2);
    run_until_done(4000, 0, -1, -1, -1, 10);
    checkOutput("t2_run_pulses", 64'(run_pulses - p0), 1);

    // Random step counts with random back-pressure.
    for (int k = 0; k < 3; k++) begin
      steps = $urandom_range(1, 3);
      p0 = run_pulses; d0 = done_cnt;
      applyStimulus(steps, steps + 1);
      run_until_done(8000, 1, -1, -1, -1, -1);
      checkOutput("rnd_run_pulses", 64'(run_pulses - p0), 64'(steps));
      checkOutput("rnd_done_count", 64'(done_cnt - d0), 1);
    end

    // T6: start while busy is ignored.
    p0 = run_pulses; d0 = done_cnt;
    applyStimulus(1, 2);
    run_until_done(4000, 0, 30, -1, -1, -1);
    checkOutput("t6_run_pulses", 64'(run_pulses - p0), 1);
    checkOutput("t6_done_count", 64'(done_cnt - d0), 1);

    // T4: unbounded run, stop at beat 5 (idx 12) of frame 4.
    p0 = run_pulses; d0 = done_cnt;
    applyStimulus(0, 5);
    run_until_done(8000, 0, -1, 4, 12, -1);
    checkOutput("t4_run_pulses", 64'(run_pulses - p0), 4);
    checkOutput("t4_done_count", 64'(done_cnt - d0), 1);

    // T5: reset in cycle 7 of a run pulse.
    applyStimulus(0, 1);
    run_seen = 0; cyc = 0;
    while (run_seen < 7 && cyc < 1000) begin
      @(posedge clkFast); #1;
      cyc++;
      if (run) run_seen++;
    end
    checkOutput("t5_run_reached", 64'(run_seen), 7);
    #2 reset = 1'b0;
    #1 check_reset_state();
    exp_q.delete();
    repeat (3) @(posedge clkFast);
    #1 reset = 1'b1;
    p0 = run_pulses; d0 = done_cnt;
    applyStimulus(1, 2);
    run_until_done(4000, 0, -1, -1, -1, -1);
    checkOutput("t5_run_pulses", 64'(run_pulses - p0), 1);
    checkOutput("t5_done_count", 64'(done_cnt - d0), 1);

    // T3: empty mask, three steps.
    num_steps_e = 16'd3;
    @(posedge clkFast); #1 start_e = 1'b1;
    @(posedge clkFast); #1 start_e = 1'b0;
    num_steps_e = 16'd0;
    got = 0; cyc = 0;
    while (!got && cyc < 1000) begin
      @(posedge clkFast); #1;
      cyc++;
      if (done_e) got = 1;
    end
    checkOutput("t3_done_seen", 64'(got), 1);
    @(posedge clkFast); #1;
    checkOutput("t3_busy_after", 64'(busy_e), 0);
    checkOutput("t3_run_pulses", 64'(run_pulses_e), 3);
    checkOutput("t3_done_count", 64'(done_cnt_e), 1);
    checkOutput("t3_no_valid", 64'(seen_valid_e), 0);
    checkOutput("t3_out_data", 64'(out_data_e), 0);
    checkOutput("t3_out_idx", 64'(out_idx_e), 0);
    checkOutput("t3_out_frame", 64'(out_frame_e), 0);
    checkOutput("t3_out_last", 64'(out_last_e), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
